display_peek_sequencer: RTL and testbench
=========================================

// Module: display_peek_sequencer
// PURPOSE
//   Sequences which register / memory word the display module peeks at.
//   Replaces raw switch selection with four modes: manual, auto-scan of the 32 registers,
//   auto-scan of a memory window, and frozen hold. Includes pause and single-step buttons.
//   Sits between board switches/buttons and the display module's regToPeek/memToPeek inputs.
// PARAMETERS
//   DWELL_CYCLES  25000000    clock cycles each scan index is shown (>=2)
//   MEM_BASE      32'h0       first byte address of memory scan window
//   MEM_WORDS     16          words in memory scan window (1..32)
//   ADDR_STRIDE   4           byte increment between scanned memory words
// PORTS
//   Clk        in   1   system clock, all logic on rising edge
//   Rst        in   1   synchronous, active-high reset
//   mode       in   2   00 MANUAL, 01 REG_SCAN, 10 MEM_SCAN, 11 HOLD
//   manualSel  in   5   register index used in MANUAL mode
//   stepBtn    in   1   level input, already synchronised; rising edge = one step
//   pauseBtn   in   1   level input, already synchronised; rising edge toggles pause
//   regToPeek  out  5   register index to display
//   memToPeek  out  32  memory byte address to display
//   srcSel     out  1   0 = show register data, 1 = show memory data
//   scanIdx    out  5   current scan index
//   paused     out  1   1 while the scan is frozen by pauseBtn
//   dwellTick  out  1   one-cycle pulse when the index advances for any reason
// BEHAVIOUR
//   - Reset (Rst=1 at a rising edge) sets every output to its reset value:
//     regToPeek=0, memToPeek=MEM_BASE, srcSel=0, scanIdx=0, paused=0, dwellTick=0.
//     Reset also sets dwell counter=0, state=MANUAL, and clears the button edge history.
//     Reset applied mid-scan takes effect at that edge; nothing is retained.
//   - Button edges: rising edge = btn & ~btn_q. The first cycle after reset never produces an edge.
//   - States: MANUAL, REG_SCAN, MEM_SCAN, HOLD. Each cycle the next state follows the mode input.
//   - On a mode change (state != decoded mode):
//     - scanIdx<=0, counter<=0, paused<=0, no dwellTick.
//     - A mode change in the same cycle as a step or pause edge wins; the edge is discarded.
//   - MANUAL: regToPeek<=manualSel (1-cycle latency), srcSel<=0, scanIdx<=manualSel.
//     The counter is held at 0. Buttons are ignored.
//   - REG_SCAN / MEM_SCAN, not paused:
//     - The counter increments each cycle.
//     - At counter==DWELL_CYCLES-1: advance, counter<=0, dwellTick=1.
//   - Advance: REG_SCAN wraps 31->0. MEM_SCAN wraps MEM_WORDS-1->0.
//   - Step edge while running: advance immediately, counter<=0.
//     A step edge coincident with dwell expiry advances once only.
//   - Pause edge toggles paused. While paused the counter holds.
//     A step edge while paused advances once; paused stays 1.
//     Pause and step in the same cycle: apply the step, then toggle pause.
//   - Outputs update on the same edge as scanIdx:
//     - REG_SCAN: regToPeek=scanIdx, srcSel=0.
//     - MEM_SCAN: memToPeek=MEM_BASE+scanIdx*ADDR_STRIDE, mod 2^32; srcSel=1.
//   - HOLD: all outputs frozen at their values when HOLD was entered. Counter 0, buttons ignored.
//     Leaving HOLD follows the normal mode-change rule.
//   - dwellTick is a 1-cycle registered pulse, never high two consecutive cycles.
// STRUCTURE
//   - display_pkg: mode encodings (MODE_MANUAL..MODE_HOLD), state localparams, NUM_REGS=32.
//   - One sub-module btn_edge_detect (Clk, Rst, in, rise), instantiated twice for step and pause.
//   - Counter width: $clog2(DWELL_CYCLES).
// TESTING (bench params: DWELL_CYCLES=4, MEM_BASE=32'h100, MEM_WORDS=3)
//   1. Rst=1 for 2 cycles then 0, mode=00, manualSel=7 -> all outputs at reset values during reset;
//      regToPeek=7 one cycle after release.
//   2. mode=01, no buttons, 10 cycles -> scanIdx 0,0,0,0,1,1,1,1,2...; dwellTick every 4th cycle.
//      Force scanIdx=31 -> wraps to 0.
//   3. mode=10 -> memToPeek 100,104,108,100 (hex); srcSel=1.
//   4. pause edge, then 8 cycles -> scanIdx constant, paused=1.
//      step edge -> +1 with dwellTick.
//      Second pause edge -> paused=0, scanning resumes.
//   5. step edge in same cycle as dwell expiry -> single advance.
//      mode change with a step edge in the same cycle -> scanIdx=0, no tick.
//   6. mode=11 mid-scan at scanIdx=2 -> outputs frozen.
//      Rst=1 pulse mid-scan -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/display_pkg.sv
// Shared mode/state encodings and address helper for the display peek sequencer.
package display_pkg;

  localparam logic [1:0] MODE_MANUAL   = 2'b00;
  localparam logic [1:0] MODE_REG_SCAN = 2'b01;
  localparam logic [1:0] MODE_MEM_SCAN = 2'b10;
  localparam logic [1:0] MODE_HOLD     = 2'b11;

  localparam int NUM_REGS = 32;

  typedef enum logic [1:0] {
    ST_MANUAL   = 2'b00,
    ST_REG_SCAN = 2'b01,
    ST_MEM_SCAN = 2'b10,
    ST_HOLD     = 2'b11
  } state_t;

  function automatic state_t mode_to_state(input logic [1:0] m);
    state_t s;
    case (m)
      MODE_MANUAL:   s = ST_MANUAL;
      MODE_REG_SCAN: s = ST_REG_SCAN;
      MODE_MEM_SCAN: s = ST_MEM_SCAN;
      MODE_HOLD:     s = ST_HOLD;
      default:       s = ST_HOLD;
    endcase
    return s;
  endfunction

  // Byte address of a scanned memory word; wraps naturally modulo 2^32.
  function automatic logic [31:0] mem_addr(input logic [31:0] base,
                                           input logic [4:0]  idx,
                                           input logic [31:0] stride);
    return base + ({27'd0, idx} * stride);
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector for an already-synchronised button level.
// The armed flag suppresses a false edge on the first cycle after reset.
module btn_edge_detect (
  input  logic Clk,
  input  logic Rst,
  input  logic in,
  output logic rise
);

  logic in_q_r;
  logic armed_r;

  // Edge history and post-reset arming.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      in_q_r  <= 1'b0;
      armed_r <= 1'b0;
    end else begin
      in_q_r  <= in;
      armed_r <= 1'b1;
    end
  end

  assign rise = in & ~in_q_r & armed_r;

endmodule

// File: rtl/display_peek_sequencer.sv
// Chooses which register index / memory address the display peeks at:
// manual select, register auto-scan, memory-window auto-scan, or frozen hold.
module display_peek_sequencer
  import display_pkg::*;
#(
  parameter int          DWELL_CYCLES = 25000000,
  parameter logic [31:0] MEM_BASE     = 32'h0,
  parameter int          MEM_WORDS    = 16,
  parameter int          ADDR_STRIDE  = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [1:0]  mode,
  input  logic [4:0]  manualSel,
  input  logic        stepBtn,
  input  logic        pauseBtn,
  output logic [4:0]  regToPeek,
  output logic [31:0] memToPeek,
  output logic        srcSel,
  output logic [4:0]  scanIdx,
  output logic        paused,
  output logic        dwellTick
);

  localparam int             CW       = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [4:0]     REG_LAST = 5'(NUM_REGS - 1);
  localparam logic [4:0]     MEM_LAST = 5'(MEM_WORDS - 1);
  localparam logic [31:0]    STRIDE   = 32'(ADDR_STRIDE);

  state_t        state_r;
  state_t        mode_st_s;
  logic [CW-1:0] cnt_r;
  logic [4:0]    idx_r;
  logic [4:0]    reg_r;
  logic [31:0]   mem_r;
  logic          src_r;
  logic          paused_r;
  logic          tick_r;
  logic          step_rise_s;
  logic          pause_rise_s;
  logic          adv_s;
  logic [4:0]    next_idx_s;

  btn_edge_detect u_step_edge (
    .Clk  (Clk),
    .Rst  (Rst),
    .in   (stepBtn),
    .rise (step_rise_s)
  );

  btn_edge_detect u_pause_edge (
    .Clk  (Clk),
    .Rst  (Rst),
    .in   (pauseBtn),
    .rise (pause_rise_s)
  );

  // Advance decision and wrapped next index for the active scan window.
  always_comb begin
    mode_st_s = mode_to_state(mode);
    adv_s     = step_rise_s | (~paused_r & (cnt_r == CNT_LAST));
    if (state_r == ST_MEM_SCAN) begin
      next_idx_s = (idx_r >= MEM_LAST) ? 5'd0 : idx_r + 5'd1;
    end else begin
      next_idx_s = (idx_r >= REG_LAST) ? 5'd0 : idx_r + 5'd1;
    end
  end

  // Sequencer state, dwell counter and registered display outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r  <= ST_MANUAL;
      cnt_r    <= '0;
      idx_r    <= 5'd0;
      reg_r    <= 5'd0;
      mem_r    <= MEM_BASE;
      src_r    <= 1'b0;
      paused_r <= 1'b0;
      tick_r   <= 1'b0;
    end else if (state_r != mode_st_s) begin
      // Mode change beats any coincident button edge; HOLD keeps the displayed view.
      state_r  <= mode_st_s;
      cnt_r    <= '0;
      paused_r <= 1'b0;
      tick_r   <= 1'b0;
      if (mode_st_s == ST_MEM_SCAN) begin
        idx_r <= 5'd0;
        mem_r <= MEM_BASE;
        src_r <= 1'b1;
      end else if (mode_st_s != ST_HOLD) begin
        idx_r <= 5'd0;
        reg_r <= 5'd0;
        src_r <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_MANUAL: begin
          reg_r  <= manualSel;
          idx_r  <= manualSel;
          src_r  <= 1'b0;
          cnt_r  <= '0;
          tick_r <= 1'b0;
        end
        ST_REG_SCAN, ST_MEM_SCAN: begin
          if (adv_s) begin
            idx_r  <= next_idx_s;
            cnt_r  <= '0;
            // A step right after a dwell expiry still advances, but the pulse stays one cycle.
            tick_r <= ~tick_r;
            if (state_r == ST_MEM_SCAN) begin
              mem_r <= mem_addr(MEM_BASE, next_idx_s, STRIDE);
              src_r <= 1'b1;
            end else begin
              reg_r <= next_idx_s;
              src_r <= 1'b0;
            end
          end else begin
            tick_r <= 1'b0;
            if (!paused_r) begin
              cnt_r <= cnt_r + CW'(1);
            end
          end
          if (pause_rise_s) begin
            paused_r <= ~paused_r;
          end
        end
        default: begin
          cnt_r  <= '0;
          tick_r <= 1'b0;
        end
      endcase
    end
  end

  assign regToPeek = reg_r;
  assign memToPeek = mem_r;
  assign srcSel    = src_r;
  assign scanIdx   = idx_r;
  assign paused    = paused_r;
  assign dwellTick = tick_r;

endmodule

// File: tb/tb_display_peek_sequencer.sv
// Scoreboard bench: a behavioural model predicts each cycle's outputs, a monitor compares them.
module tb_display_peek_sequencer;

  localparam int          DWELL  = 4;
  localparam logic [31:0] BASE   = 32'h100;
  localparam int          WORDS  = 3;
  localparam int          STRIDE = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  sel = 5'd7;
  logic        step = 1'b0;
  logic        pause = 1'b0;
  logic [4:0]  reg_o;
  logic [31:0] mem_o;
  logic        src_o;
  logic [4:0]  idx_o;
  logic        paused_o;
  logic        tick_o;

  display_peek_sequencer #(
    .DWELL_CYCLES(DWELL), .MEM_BASE(BASE), .MEM_WORDS(WORDS), .ADDR_STRIDE(STRIDE)
  ) dut (
    .Clk(clk), .Rst(rst), .mode(mode), .manualSel(sel), .stepBtn(step), .pauseBtn(pause),
    .regToPeek(reg_o), .memToPeek(mem_o), .srcSel(src_o), .scanIdx(idx_o),
    .paused(paused_o), .dwellTick(tick_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [31:0] m;
    bit          s;
    int          i;
    bit          p;
    bit          t;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Model state: mode 0..3, scan index, dwell count, pause flag and displayed view.
  int          m_st = 0, m_idx = 0, m_cnt = 0, m_reg = 0;
  bit          m_paused = 0, m_tick = 0, m_src = 0;
  logic [31:0] m_mem = BASE;
  bit          m_ps = 0, m_pp = 0, m_armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  task automatic model(input bit r, input int md, input int s, input bit st, input bit pa);
    bit se, pe, expire, nt;
    int n;
    exp_t e;
    if (r) begin
      m_st = 0; m_idx = 0; m_cnt = 0; m_reg = 0; m_paused = 0; m_tick = 0;
      m_src = 0; m_mem = BASE; m_ps = 0; m_pp = 0; m_armed = 0;
    end else begin
      se = m_armed && st && !m_ps;
      pe = m_armed && pa && !m_pp;
      m_ps = st; m_pp = pa; m_armed = 1;
      nt = 0;
      if (md != m_st) begin
        if (md == 2) begin m_idx = 0; m_mem = BASE; m_src = 1; end
        else if (md != 3) begin m_idx = 0; m_reg = 0; m_src = 0; end
        m_cnt = 0; m_paused = 0; m_st = md;
      end else if (m_st == 0) begin
        m_reg = s; m_idx = s; m_src = 0; m_cnt = 0;
      end else if (m_st == 3) begin
        m_cnt = 0;
      end else begin
        expire = !m_paused && (m_cnt == DWELL - 1);
        if (se || expire) begin
          n = (m_st == 1) ? 32 : WORDS;
          m_idx = (m_idx + 1) % n;
          m_cnt = 0;
          nt = !m_tick;
          if (m_st == 1) begin m_reg = m_idx; m_src = 0; end
          else begin m_mem = BASE + 32'(m_idx * STRIDE); m_src = 1; end
        end else if (!m_paused) begin
          m_cnt++;
        end
        if (pe) m_paused = !m_paused;
      end
      m_tick = nt;
    end
    e.r = m_reg; e.m = m_mem; e.s = m_src; e.i = m_idx; e.p = m_paused; e.t = m_tick;
    sb.push_back(e);
  endtask

  task automatic cycle(input bit r, input int md, input int s, input bit st, input bit pa);
    @(negedge clk);
    rst = r; mode = 2'(md); sel = 5'(s); step = st; pause = pa;
    model(r, md, s, st, pa);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  // Monitor: outputs are valid every cycle; compare against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("regToPeek", 32'(reg_o), 32'(e.r));
        chk("memToPeek", mem_o, e.m);
        chk("srcSel", 32'(src_o), 32'(e.s));
        chk("scanIdx", 32'(idx_o), 32'(e.i));
        chk("paused", 32'(paused_o), 32'(e.p));
        chk("dwellTick", 32'(tick_o), 32'(e.t));
      end
    end
  end

  initial begin
    int md, s;
    bit st, pa, r;
    // Reset held two cycles with manual select 7, then release.
    cycle(1, 0, 7, 0, 0);
    cycle(1, 0, 7, 0, 0);
    cycle(0, 0, 7, 0, 0);
    settle();
    chk("manual_latency", 32'(reg_o), 32'd7);
    cycle(0, 0, 7, 0, 0);
    // Register scan long enough to wrap 31 -> 0.
    for (int i = 0; i < 4 * 32 + 6; i++) cycle(0, 1, 0, 0, 0);
    // Memory scan window wraps after three words.
    for (int i = 0; i < 16; i++) cycle(0, 2, 0, 0, 0);
    // Pause, step while paused, resume.
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0);
    settle();
    chk("paused_hold", 32'(paused_o), 32'd1);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0, 0, 0);
    // Step coincident with dwell expiry.
    for (int i = 0; i < 20 && m_cnt != DWELL - 1; i++) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    // Mode change with a step edge in the same cycle.
    cycle(0, 2, 0, 1, 0);
    cycle(0, 2, 0, 0, 0);
    // Freeze into HOLD at index 2, leave, then reset mid-scan.
    for (int i = 0; i < 40 && m_idx != 2; i++) cycle(0, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 3, 0, 0, 0);
    settle();
    chk("hold_idx", 32'(idx_o), 32'd2);
    chk("hold_mem", mem_o, 32'h108);
    for (int i = 0; i < 6; i++) cycle(0, 2, 0, 0, 0);
    cycle(1, 2, 0, 0, 0);
    settle();
    chk("reset_mem", mem_o, BASE);
    chk("reset_src", 32'(src_o), 32'd0);
    // Randomized traffic.
    md = 1; st = 0; pa = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) md = $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) st = ~st;
      if ($urandom_range(0, 6) == 0) pa = ~pa;
      r = ($urandom_range(0, 199) == 0);
      s = $urandom_range(0, 31);
      cycle(r, md, s, st, pa);
    end
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
